// File: rtl/coherence_soc_axil_regs.sv
// AXI4-Lite slave holding four 32-bit control registers for the coherence core.
// Write address and data are captured independently; the register update and B response follow one edge later.
module coherence_soc_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   REG_OUT
);

    localparam int         STRB_W      = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_width
        $error("coherence_soc_axil_regs supports only a 32-bit data bus");
    end
    if (C_S_AXI_ADDR_WIDTH < 4) begin : g_bad_addr
        $error("coherence_soc_axil_regs needs at least 4 address bits");
    end

    logic [3:0][C_S_AXI_DATA_WIDTH-1:0] regs;

    logic                          aw_held;
    logic [1:0]                    aw_word;
    logic                          aw_oor;
    logic                          w_held;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]             w_strb;
    logic                          bvalid;
    logic [1:0]                    bresp;

    logic                          rvalid;
    logic [1:0]                    rresp;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic aw_oor_in;
    logic ar_oor_in;

    // Any address bit above the word select marks the access as out of range.
    if (C_S_AXI_ADDR_WIDTH > 4) begin : g_range
        assign aw_oor_in = |S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:4];
        assign ar_oor_in = |S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4];
    end else begin : g_no_range
        assign aw_oor_in = 1'b0;
        assign ar_oor_in = 1'b0;
    end

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    function automatic logic [C_S_AXI_DATA_WIDTH-1:0] merge_strb(
        input logic [C_S_AXI_DATA_WIDTH-1:0] old_v,
        input logic [C_S_AXI_DATA_WIDTH-1:0] new_v,
        input logic [STRB_W-1:0]             strb
    );
        logic [C_S_AXI_DATA_WIDTH-1:0] res;
        res = old_v;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_v[i*8 +: 8];
            end
        end
        return res;
    endfunction

    assign S_AXI_AWREADY = !aw_held && !bvalid;
    assign S_AXI_WREADY  = !w_held && !bvalid;
    assign S_AXI_ARREADY = !rvalid;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // Write path: capture AW and W separately, commit once both are held.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_held <= 1'b0;
            aw_word <= '0;
            aw_oor  <= 1'b0;
            w_held  <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            regs    <= '0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_word <= S_AXI_AWADDR[3:2];
                aw_oor  <= aw_oor_in;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            // Both flags set implies BVALID is low, so commit and B handshake never overlap.
            if (aw_held && w_held) begin
                if (!aw_oor) begin
                    regs[aw_word] <= merge_strb(regs[aw_word], w_data, w_strb);
                end
                bresp   <= aw_oor ? RESP_SLVERR : RESP_OKAY;
                bvalid  <= 1'b1;
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else if (bvalid && S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Read path: sampling regs with a non-blocking read returns the pre-update value on a collision.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid <= 1'b0;
            rresp  <= RESP_OKAY;
            rdata  <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rresp  <= ar_oor_in ? RESP_SLVERR : RESP_OKAY;
            rdata  <= ar_oor_in ? '0 : regs[S_AXI_ARADDR[3:2]];
        end else if (rvalid && S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end

    assign S_AXI_BVALID = bvalid;
    assign S_AXI_BRESP  = bresp;
    assign S_AXI_RVALID = rvalid;
    assign S_AXI_RRESP  = rresp;
    assign S_AXI_RDATA  = rdata;
    assign REG_OUT      = regs;

endmodule

// File: tb/tb_coherence_soc_axil_regs.sv
// Scoreboard bench for coherence_soc_axil_regs: stimulus queues expected B/R responses, a monitor checks them.
module tb_coherence_soc_axil_regs;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [5:0]   awaddr = '0;
    logic [2:0]   awprot = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [5:0]   araddr = '0;
    logic [2:0]   arprot = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [127:0] reg_out;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } rexp_t;

    logic [1:0] exp_b[$];
    rexp_t      exp_r[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    coherence_soc_axil_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(6)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .REG_OUT      (reg_out)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: handshake not seen, expected within 100 cycles", name);
    endtask

    // Monitor: compare every completed B and R beat against the head of its queue.
    always @(negedge clk) begin
        if (bvalid && bready) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected", 1, 0);
            end else begin
                check("bresp", bresp, exp_b.pop_front());
            end
        end
        if (rvalid && rready) begin
            if (exp_r.size() == 0) begin
                check("r_unexpected", 1, 0);
            end else begin
                rexp_t e;
                e = exp_r.pop_front();
                check("rresp", rresp, e.resp);
                check("rdata", rdata, e.data);
            end
        end
    end

    task automatic hs_aw(input logic [5:0] a);
        bit hs = 1'b0;
        awaddr  = a;
        awvalid = 1'b1;
        for (int c = 0; c < 100 && !hs; c++) begin
            @(negedge clk); hs = awready;
            @(posedge clk); #1;
        end
        awvalid = 1'b0;
        if (!hs) timeout("aw_handshake");
    endtask

    task automatic hs_w(input logic [31:0] d, input logic [3:0] s);
        bit hs = 1'b0;
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        for (int c = 0; c < 100 && !hs; c++) begin
            @(negedge clk); hs = wready;
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        if (!hs) timeout("w_handshake");
    endtask

    task automatic ar_issue(input logic [5:0] a);
        bit hs = 1'b0;
        araddr  = a;
        arvalid = 1'b1;
        for (int c = 0; c < 100 && !hs; c++) begin
            @(negedge clk); hs = arready;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        if (!hs) timeout("ar_handshake");
    endtask

    task automatic wait_b();
        bit done = 1'b0;
        bready = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk); done = bvalid;
            @(posedge clk); #1;
        end
        bready = 1'b0;
        if (!done) timeout("b_handshake");
    endtask

    task automatic wait_r();
        bit done = 1'b0;
        rready = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk); done = rvalid;
            @(posedge clk); #1;
        end
        rready = 1'b0;
        if (!done) timeout("r_handshake");
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] er);
        bit aw_hs;
        bit w_hs;
        exp_b.push_back(er);
        awaddr = a; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int c = 0; c < 100 && (awvalid || wvalid); c++) begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs) wvalid = 1'b0;
        end
        if (awvalid || wvalid) timeout("write_addr_data");
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wait_b();
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [1:0] er, input logic [31:0] ed);
        rexp_t e;
        e.resp = er;
        e.data = ed;
        exp_r.push_back(e);
        ar_issue(a);
        wait_r();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_reg_out", reg_out, 0);
        check("rst_rdata", rdata, 0);
        check("rst_bresp", bresp, 0);
        check("rst_ready", {awready, wready, arready}, 3'b111);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Sequential write and readback
        axi_write(6'h00, 32'h1, 4'hF, OKAY);
        axi_write(6'h04, 32'h2, 4'hF, OKAY);
        axi_write(6'h08, 32'h3, 4'hF, OKAY);
        axi_write(6'h0C, 32'h4, 4'hF, OKAY);
        check("seq_reg_out", reg_out, 128'h00000004_00000003_00000002_00000001);
        axi_read(6'h00, OKAY, 32'h1);
        axi_read(6'h04, OKAY, 32'h2);
        axi_read(6'h08, OKAY, 32'h3);
        axi_read(6'h0C, OKAY, 32'h4);

        // Byte strobes
        axi_write(6'h04, 32'hAABBCCDD, 4'hF, OKAY);
        axi_write(6'h04, 32'h11223344, 4'b0101, OKAY);
        axi_read(6'h04, OKAY, 32'hAA22CC44);

        // Out of range
        axi_write(6'h10, 32'hDEADBEEF, 4'hF, SLVERR);
        axi_read(6'h10, SLVERR, 32'h0);
        check("oor_reg_out", reg_out, 128'h00000004_00000003_AA22CC44_00000001);

        // W five cycles ahead of AW, BREADY low for four cycles
        exp_b.push_back(OKAY);
        hs_w(32'h12345678, 4'hF);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("skew_w_wready_held", wready, 0);
        end
        hs_aw(6'h08);
        check("skew_w_bvalid_early", bvalid, 0);
        @(posedge clk); #1;
        check("skew_w_bvalid", bvalid, 1);
        for (int i = 0; i < 4; i++) begin
            check("skew_w_ready_while_b", {awready, wready, bvalid}, 3'b001);
            @(posedge clk); #1;
        end
        wait_b();

        // AW three cycles ahead of W
        exp_b.push_back(OKAY);
        hs_aw(6'h0C);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("skew_aw_awready_held", awready, 0);
        end
        hs_w(32'hCAFEF00D, 4'hF);
        check("skew_aw_bvalid_early", bvalid, 0);
        @(posedge clk); #1;
        check("skew_aw_bvalid", bvalid, 1);
        for (int i = 0; i < 4; i++) begin
            check("skew_aw_ready_while_b", {awready, wready, bvalid}, 3'b001);
            @(posedge clk); #1;
        end
        wait_b();
        check("skew_reg_out", reg_out, 128'hCAFEF00D_12345678_AA22CC44_00000001);
        axi_read(6'h08, OKAY, 32'h12345678);

        // Read/write collision on reg2
        axi_write(6'h08, 32'h5, 4'hF, OKAY);
        begin
            rexp_t e;
            e.resp = OKAY;
            e.data = 32'h5;
            exp_r.push_back(e);
        end
        exp_b.push_back(OKAY);
        bready = 1'b1;
        awaddr = 6'h08; wdata = 32'h9; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        check("coll_aw_w_ready", {awready, wready}, 2'b11);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 6'h08; arvalid = 1'b1; rready = 1'b1;
        @(negedge clk);
        check("coll_arready", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("coll_b_r_valid", {bvalid, rvalid}, 2'b11);
        @(posedge clk); #1;
        check("coll_b_r_done", {bvalid, rvalid}, 2'b00);
        bready = 1'b0; rready = 1'b0;
        axi_read(6'h08, OKAY, 32'h9);

        // Reset while AW is held and a read response is stalled
        hs_aw(6'h00);
        ar_issue(6'h04);
        check("prerst_rvalid", rvalid, 1);
        check("prerst_awready", awready, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_bvalid", bvalid, 0);
        check("midrst_rvalid", rvalid, 0);
        check("midrst_reg_out", reg_out, 0);
        check("midrst_ready", {awready, wready, arready}, 3'b111);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        axi_write(6'h00, 32'h7, 4'hF, OKAY);
        check("postrst_reg_out", reg_out, 128'h7);
        axi_read(6'h04, OKAY, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check("exp_b_drained", exp_b.size(), 0);
        check("exp_r_drained", exp_r.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
